// File: rtl/cmd_dispatch_fifo_bank_pkg.sv
// ----------------------------------------------------------------------------
// cmd_dispatch_fifo_bank_pkg
// Shared constants and command decode for the command-routed FIFO bank.
//   CMD_BCAST        : command byte that targets every engine channel
//   DEF_*            : default parameter values for the bank and its FIFOs
//   cmd_kind_e       : unicast / broadcast / invalid classification
//   decode_cmd()     : classifies a command byte for a given engine count
// ----------------------------------------------------------------------------
package cmd_dispatch_fifo_bank_pkg;

   localparam logic [7:0] CMD_BCAST = 8'hFF;

   localparam int DEF_NUM_ENGINES = 5;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_DEPTH       = 16;
   localparam int DEF_LOG2DEPTH   = 4;

   typedef enum logic [1:0] {
      CMD_UNICAST   = 2'd0,
      CMD_BROADCAST = 2'd1,
      CMD_INVALID   = 2'd2
   } cmd_kind_e;

   // Broadcast is tested first so the 8'hFF code can never alias a channel.
   function automatic cmd_kind_e decode_cmd(input logic [7:0] cmd,
                                            input int         num_engines);
      if (cmd == CMD_BCAST)
         return CMD_BROADCAST;
      else if (int'(cmd) < num_engines)
         return CMD_UNICAST;
      return CMD_INVALID;
   endfunction

endpackage

// File: rtl/cmd_dispatch_fifo_bank_sync_fifo_fwft.sv
// ----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO, one per engine channel.
//   clk, rst_  : clock, asynchronous active-high reset (control state only)
//   push       : write in_data when not full (push while full is ignored)
//   in_data    : write word
//   full       : count == DEPTH
//   pop        : consume the head word when not empty
//   out_data   : head word, zero while empty
//   empty      : count == 0
//   count      : occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo_fwft
   import cmd_dispatch_fifo_bank_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int LOG2DEPTH  = DEF_LOG2DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  full,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  empty,
   output logic [LOG2DEPTH:0]    count
);

   localparam logic [LOG2DEPTH:0] FULL_CNT = (LOG2DEPTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [LOG2DEPTH-1:0]  r_wr_ptr;
   logic [LOG2DEPTH-1:0]  r_rd_ptr;
   logic [LOG2DEPTH:0]    r_count;
   logic                  w_push_ok;
   logic                  w_pop_ok;

   // Fullness is judged on the registered count, so a pop in the same cycle
   // does not open room for a push into a full FIFO.
   assign w_push_ok = push && (r_count != FULL_CNT);
   assign w_pop_ok  = pop  && (r_count != '0);

   // Storage carries no reset; emptiness masks stale contents on out_data.
   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + LOG2DEPTH'(1);
         if (w_pop_ok)
            r_rd_ptr <= r_rd_ptr + LOG2DEPTH'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (LOG2DEPTH+1)'(1);
            2'b01:   r_count <= r_count - (LOG2DEPTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign empty    = (r_count == '0);
   assign full     = (r_count == FULL_CNT);
   assign count    = r_count;
   assign out_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/cmd_dispatch_fifo_bank.sv
// ----------------------------------------------------------------------------
// cmd_dispatch_fifo_bank
// Routes command-tagged words into per-engine FWFT FIFOs (unicast or
// broadcast); invalid commands are consumed, dropped and flagged.
//   clk, rst_   : clock, asynchronous active-high reset
//   in_cmd      : routing command (< NUM_ENGINES unicast, 8'hFF broadcast)
//   in_data     : write word
//   in_rts      : upstream has a word
//   in_rtr      : bank accepts the presented word (depends on in_cmd only)
//   out_data    : channel i head word in [i*DATA_WIDTH +: DATA_WIDTH]
//   out_rts     : channel i non-empty
//   out_rtr     : engine i accepts its head word
//   fill_count  : channel i occupancy in [i*(LOG2DEPTH+1) +: LOG2DEPTH+1]
//   cmd_err     : sticky invalid-command flag
//   err_clr     : clears cmd_err (a simultaneous new error wins)
// ----------------------------------------------------------------------------
module cmd_dispatch_fifo_bank
   import cmd_dispatch_fifo_bank_pkg::*;
#(
   parameter int NUM_ENGINES = DEF_NUM_ENGINES,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int LOG2DEPTH   = DEF_LOG2DEPTH
) (
   input  logic                                 clk,
   input  logic                                 rst_,
   input  logic [7:0]                           in_cmd,
   input  logic [DATA_WIDTH-1:0]                in_data,
   input  logic                                 in_rts,
   output logic                                 in_rtr,
   output logic [NUM_ENGINES*DATA_WIDTH-1:0]    out_data,
   output logic [NUM_ENGINES-1:0]               out_rts,
   input  logic [NUM_ENGINES-1:0]               out_rtr,
   output logic [NUM_ENGINES*(LOG2DEPTH+1)-1:0] fill_count,
   output logic                                 cmd_err,
   input  logic                                 err_clr
);

   localparam int CW = LOG2DEPTH + 1;

   cmd_kind_e              w_kind;
   logic [NUM_ENGINES-1:0] w_full;
   logic [NUM_ENGINES-1:0] w_empty;
   logic [NUM_ENGINES-1:0] w_push;
   logic                   w_sel_full;
   logic                   w_xfer;

   assign w_kind = decode_cmd(in_cmd, NUM_ENGINES);

   // Mux the addressed channel's full flag without indexing out of range.
   always_comb begin
      w_sel_full = 1'b0;
      for (int i = 0; i < NUM_ENGINES; i++)
         if (in_cmd == 8'(i))
            w_sel_full = w_full[i];
   end

   // Broadcast waits until every channel has room so all are written together.
   always_comb begin
      in_rtr = 1'b1;
      case (w_kind)
         CMD_UNICAST:   in_rtr = !w_sel_full;
         CMD_BROADCAST: in_rtr = !(|w_full);
         default:       in_rtr = 1'b1;
      endcase
   end

   assign w_xfer = in_rts && in_rtr;

   always_comb begin
      w_push = '0;
      for (int i = 0; i < NUM_ENGINES; i++)
         w_push[i] = w_xfer && ((w_kind == CMD_BROADCAST) ||
                                ((w_kind == CMD_UNICAST) && (in_cmd == 8'(i))));
   end

   for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_chan
      sync_fifo_fwft #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH),
         .LOG2DEPTH  (LOG2DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst_     (rst_),
         .push     (w_push[g]),
         .in_data  (in_data),
         .full     (w_full[g]),
         .pop      (out_rtr[g]),
         .out_data (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
         .empty    (w_empty[g]),
         .count    (fill_count[g*CW +: CW])
      );
   end

   assign out_rts = ~w_empty;

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_)
         cmd_err <= 1'b0;
      else if (w_xfer && (w_kind == CMD_INVALID))
         cmd_err <= 1'b1;
      else if (err_clr)
         cmd_err <= 1'b0;
   end

endmodule

// File: tb/tb_cmd_dispatch_fifo_bank.sv
module tb_cmd_dispatch_fifo_bank;

   localparam int NE    = 5;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int LD    = 4;
   localparam int CW    = LD + 1;

   logic             clk = 1'b0;
   logic             rst_ = 1'b0;
   logic [7:0]       in_cmd = 8'd0;
   logic [DW-1:0]    in_data = '0;
   logic             in_rts = 1'b0;
   logic             in_rtr;
   logic [NE*DW-1:0] out_data;
   logic [NE-1:0]    out_rts;
   logic [NE-1:0]    out_rtr = '0;
   logic [NE*CW-1:0] fill_count;
   logic             cmd_err;
   logic             err_clr = 1'b0;

   cmd_dispatch_fifo_bank #(
      .NUM_ENGINES (NE),
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .LOG2DEPTH   (LD)
   ) dut (
      .clk        (clk),
      .rst_       (rst_),
      .in_cmd     (in_cmd),
      .in_data    (in_data),
      .in_rts     (in_rts),
      .in_rtr     (in_rtr),
      .out_data   (out_data),
      .out_rts    (out_rts),
      .out_rtr    (out_rtr),
      .fill_count (fill_count),
      .cmd_err    (cmd_err),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model: one queue per engine ----------------
   logic [7:0] mq [NE][$];
   logic       m_err = 1'b0;

   function automatic logic m_rtr(input logic [7:0] c);
      if (c == 8'hFF) begin
         for (int i = 0; i < NE; i++)
            if (mq[i].size() >= DEPTH) return 1'b0;
         return 1'b1;
      end
      if (int'(c) < NE) return (mq[int'(c)].size() < DEPTH);
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst_) begin : model_step
      logic rdy, xfer, inval;
      if (rst_) begin
         for (int i = 0; i < NE; i++) mq[i].delete();
         m_err = 1'b0;
      end else begin
         rdy   = m_rtr(in_cmd);
         xfer  = in_rts && rdy;
         inval = (in_cmd != 8'hFF) && (int'(in_cmd) >= NE);
         for (int i = 0; i < NE; i++)
            if (mq[i].size() > 0 && out_rtr[i]) void'(mq[i].pop_front());
         if (xfer && !inval)
            for (int i = 0; i < NE; i++)
               if (in_cmd == 8'hFF || int'(in_cmd) == i) mq[i].push_back(in_data);
         if (xfer && inval) m_err = 1'b1;
         else if (err_clr)  m_err = 1'b0;
      end
   end

   always @(negedge clk) begin : compare
      chk("in_rtr", 64'(in_rtr), 64'(m_rtr(in_cmd)));
      chk("cmd_err", 64'(cmd_err), 64'(m_err));
      for (int i = 0; i < NE; i++) begin
         chk($sformatf("out_rts[%0d]", i), 64'(out_rts[i]), 64'(mq[i].size() != 0));
         chk($sformatf("fill[%0d]", i), 64'(fill_count[i*CW +: CW]), 64'(mq[i].size()));
         if (mq[i].size() != 0)
            chk($sformatf("head[%0d]", i), 64'(out_data[i*DW +: DW]), 64'(mq[i][0]));
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic post_reset_unicast;
      in_cmd = 8'd2; in_data = 8'hA5; in_rts = 1'b1; out_rtr = '0;
      #1;
      chk("t1_in_rtr", 64'(in_rtr), 64'd1);
      tick;
      in_rts = 1'b0;
      chk("t1_out_rts", 64'(out_rts), 64'b00100);
      chk("t1_data2", 64'(out_data[23:16]), 64'hA5);
      chk("t1_fill", 64'(fill_count), 64'h400);
      out_rtr = 5'b00100;
      tick;
      out_rtr = '0;
      chk("t1_drained", 64'(out_rts), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int d;
      logic w;
      int pct;
      int p;
      #1 rst_ = 1'b1;
      tick; tick;
      chk("rst_out_rts", 64'(out_rts), 64'd0);
      chk("rst_fill", 64'(fill_count), 64'd0);
      chk("rst_cmd_err", 64'(cmd_err), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      rst_ = 1'b0;

      // 1: unicast
      post_reset_unicast();

      // 2: broadcast, then blocked broadcast with channel 0 full
      in_cmd = 8'hFF; in_data = 8'h3C; in_rts = 1'b1;
      #1;
      chk("t2_in_rtr", 64'(in_rtr), 64'd1);
      tick;
      in_rts = 1'b0;
      chk("t2_out_rts", 64'(out_rts), 64'b11111);
      chk("t2_data", 64'(out_data), 64'h3C3C3C3C3C);
      chk("t2_fill", 64'(fill_count), 64'h108421);
      out_rtr = '1; tick; out_rtr = '0;
      in_cmd = 8'd0; in_rts = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_data = 8'(k);
         tick;
      end
      in_rts = 1'b0;
      in_cmd = 8'hFF; in_data = 8'h77; in_rts = 1'b1;
      #1;
      chk("t2_bcast_blocked", 64'(in_rtr), 64'd0);
      tick;
      in_rts = 1'b0;
      chk("t2_fill_unchanged", 64'(fill_count), 64'h10);
      chk("t2_rts_unchanged", 64'(out_rts), 64'b00001);
      chk("t2_head0", 64'(out_data[7:0]), 64'h00);
      out_rtr = 5'b00001;
      repeat (16) tick;
      out_rtr = '0;

      // 3: channel 4 full, then wrap with push/pop pairs
      in_cmd = 8'd4; in_rts = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_data = 8'(k);
         tick;
      end
      in_rts = 1'b0;
      chk("t3_full_count", 64'(fill_count), 64'h1000000);
      d = 16;
      for (int k = 0; k < 32; k++) begin
         in_rts = (d < 32); in_data = 8'(d); out_rtr = 5'b10000;
         #1;
         if (k == 0) chk("t3_rtr_full", 64'(in_rtr), 64'd0);
         chk("t3_order", 64'(out_data[39:32]), 64'(k));
         w = in_rts && in_rtr;
         tick;
         if (w) d++;
      end
      in_rts = 1'b0; out_rtr = '0;
      chk("t3_pushes", 64'(d), 64'd32);
      chk("t3_empty", 64'(out_rts), 64'd0);

      // 4: invalid command and cmd_err set/clear priority
      in_cmd = 8'h07; in_data = 8'h11; in_rts = 1'b1;
      #1;
      chk("t4_in_rtr", 64'(in_rtr), 64'd1);
      tick;
      in_rts = 1'b0;
      chk("t4_err_set", 64'(cmd_err), 64'd1);
      chk("t4_dropped", 64'(out_rts), 64'd0);
      in_rts = 1'b1; err_clr = 1'b1;
      tick;
      in_rts = 1'b0;
      chk("t4_set_wins", 64'(cmd_err), 64'd1);
      tick;
      err_clr = 1'b0;
      chk("t4_cleared", 64'(cmd_err), 64'd0);

      // 5: channel 1 at 8, simultaneous push and pop
      in_cmd = 8'd1; in_rts = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_data = 8'h50 + 8'(k);
         tick;
      end
      in_data = 8'h99; out_rtr = 5'b00010;
      tick;
      in_rts = 1'b0; out_rtr = '0;
      chk("t5_count", 64'(fill_count[9:5]), 64'd8);
      chk("t5_head", 64'(out_data[15:8]), 64'h51);
      out_rtr = 5'b00010;
      repeat (8) tick;
      out_rtr = '0;

      // 6: asynchronous reset mid-burst
      in_rts = 1'b1;
      for (int k = 0; k < 7; k++) begin
         in_cmd = 8'd3; in_data = 8'(k); tick;
         if (k < 5) begin in_cmd = 8'd2; tick; end
         if (k < 3) begin in_cmd = 8'd0; tick; end
      end
      in_rts = 1'b0;
      @(posedge clk);
      #3 rst_ = 1'b1;
      #1;
      chk("t6_rts_async", 64'(out_rts), 64'd0);
      chk("t6_fill_async", 64'(fill_count), 64'd0);
      chk("t6_data_async", 64'(out_data), 64'd0);
      tick; tick;
      rst_ = 1'b0;
      post_reset_unicast();

      // random traffic: low drain rate first to reach full, then high
      for (int k = 0; k < 3000; k++) begin
         pct = (k < 1500) ? 25 : 75;
         p = int'($urandom_range(99));
         if (p < 70)      in_cmd = 8'($urandom_range(NE-1));
         else if (p < 85) in_cmd = 8'hFF;
         else             in_cmd = 8'($urandom_range(254, NE));
         in_data = 8'($urandom);
         in_rts  = ($urandom_range(3) != 0);
         for (int i = 0; i < NE; i++) out_rtr[i] = (int'($urandom_range(99)) < pct);
         err_clr = ($urandom_range(15) == 0);
         tick;
      end
      in_rts = 1'b0; out_rtr = '0; err_clr = 1'b0;
      tick;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
